// File: rtl/rotary_input_conditioner.sv
// Rotary encoder / push-button front end: 2-FF sync, per-input debounce, quadrature detent decode,
// and a stretched rot_event pulse with a one-deep pending slot.
//
//   state | meaning
//   REST  | at detent, AB = 11
//   CW1   | CW started, AB = 01
//   CW2   | CW midway, AB = 00
//   CW3   | CW last quarter, AB = 10; 11 completes a CW detent
//   CCW1  | CCW started, AB = 10
//   CCW2  | CCW midway, AB = 00
//   CCW3  | CCW last quarter, AB = 01; 11 completes a CCW detent
//   ERR   | illegal jump seen, waiting for AB = 11
module rotary_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int EVENT_HOLD      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rot_a,
  input  logic rot_b,
  input  logic rot_press,
  output logic rot_event,
  output logic rot_dir,
  output logic pb_level,
  output logic pb_pulse,
  output logic evt_overflow
);

  typedef enum logic [2:0] {REST, CW1, CW2, CW3, CCW1, CCW2, CCW3, ERR} quad_state_t;

  localparam logic [2:0] RAW_IDLE = 3'b110;  // {a, b, press}
  localparam int HOLD_W = (EVENT_HOLD > 1) ? $clog2(EVENT_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(EVENT_HOLD - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       sync1, sync2, deb, deb_load;
  logic [CNT_W-1:0] cnt [3];
  logic [1:0]       ab;
  quad_state_t      state, state_nxt;
  wire              det_cw, det_ccw;
  logic             detent;
  logic             pending, pend_dir;
  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
    end else begin
      sync1 <= {rot_a, rot_b, rot_press};
      sync2 <= sync1;
    end
  end

  always_comb begin
    deb_load = '0;
    for (int i = 0; i < 3; i++) begin
      deb_load[i] = (sync2[i] != deb[i]) && (cnt[i] == DEB_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= RAW_IDLE;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (deb_load[i]) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign ab       = deb[2:1];
  assign pb_level = deb[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pb_pulse <= 1'b0;
    else        pb_pulse <= deb_load[0] & sync2[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= REST;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      REST: case (ab)
        2'b01:   state_nxt = CW1;
        2'b10:   state_nxt = CCW1;
        2'b00:   state_nxt = ERR;
        default: ;
      endcase
      CW1: case (ab)
        2'b00:   state_nxt = CW2;
        2'b11:   state_nxt = REST;
        2'b10:   state_nxt = ERR;
        default: ;
      endcase
      CW2: case (ab)
        2'b10:   state_nxt = CW3;
        2'b01:   state_nxt = CW1;
        2'b11:   state_nxt = REST;
        default: ;
      endcase
      CW3: case (ab)
        2'b11:   state_nxt = REST;
        2'b00:   state_nxt = CW2;
        2'b01:   state_nxt = ERR;
        default: ;
      endcase
      CCW1: case (ab)
        2'b00:   state_nxt = CCW2;
        2'b11:   state_nxt = REST;
        2'b01:   state_nxt = ERR;
        default: ;
      endcase
      CCW2: case (ab)
        2'b01:   state_nxt = CCW3;
        2'b10:   state_nxt = CCW1;
        2'b11:   state_nxt = REST;
        default: ;
      endcase
      CCW3: case (ab)
        2'b11:   state_nxt = REST;
        2'b00:   state_nxt = CCW2;
        2'b10:   state_nxt = ERR;
        default: ;
      endcase
      ERR:     if (ab == 2'b11) state_nxt = REST;
      default: state_nxt = REST;
    endcase
  end

  // Detent is flagged while the FSM still sits in its last quarter, so rot_event rises one edge after AB returns to 11.
  assign det_cw  = (state == CW3)  && (ab == 2'b11);
  assign det_ccw = (state == CCW3) && (ab == 2'b11);
  assign detent  = det_cw | det_ccw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_event    <= 1'b0;
      rot_dir      <= 1'b0;
      hold_cnt     <= '0;
      pending      <= 1'b0;
      pend_dir     <= 1'b0;
      evt_overflow <= 1'b0;
    end else begin
      if (rot_event) begin
        if (hold_cnt == '0) rot_event <= 1'b0;
        else                hold_cnt  <= hold_cnt - 1'b1;
      end else if (pending) begin
        rot_event <= 1'b1;
        rot_dir   <= pend_dir;
        hold_cnt  <= HOLD_LOAD;
        pending   <= 1'b0;
      end else if (detent) begin
        rot_event <= 1'b1;
        rot_dir   <= det_cw;
        hold_cnt  <= HOLD_LOAD;
      end
      // A detent that cannot go out now is parked; a full slot (even one being drained this edge) drops it.
      if (detent && (rot_event || pending)) begin
        if (pending) begin
          evt_overflow <= 1'b1;
        end else begin
          pending  <= 1'b1;
          pend_dir <= det_cw;
        end
      end
    end
  end

endmodule
